m_dram_axi_master: RTL and testbench

AXI4 master that turns single-word core memory requests into single-beat 128-bit AXI4 transactions for the DDR3 controller's AXI slave port. It sits in the Arty A7 top level between the core memory path and the MIG `s_axi_*` port, and runs in the `ui_clk` domain. It holds at most one outstanding transaction and reports `bresp`/`rresp` errors.

---
 rtl/m_dram_axi_master_pkg.sv | 28 ++
 rtl/m_dram_axi_master_if.sv | 101 ++++++++++
 rtl/m_dram_axi_master_lane_sel.sv | 24 ++
 rtl/m_dram_axi_master.sv | 176 +++++++++++++++++
 tb/tb_m_dram_axi_master.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/m_dram_axi_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dram_axi_pkg
//  Purpose  : Shared state encoding and AXI constants for m_dram_axi_master.
//  Revision : 1.0  initial release
// ============================================================================
package dram_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } state_e;

  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Any response code other than OKAY is reported to the core as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/m_dram_axi_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : m_dram_axi_master_if
//  Purpose  : Core request/response port plus AXI4 master bundle toward MIG.
//  Revision : 1.0  initial release
// ============================================================================
interface m_dram_axi_master_if #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16
);
  // core side
  logic                      init_calib_complete;
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [APP_ADDR_WIDTH-1:0] req_addr;
  logic [31:0]               req_wdata;
  logic [3:0]                req_wstrb;
  logic                      resp_valid;
  logic [31:0]               resp_rdata;
  logic                      resp_err;
  // AXI write address
  logic [3:0]                m_axi_awid;
  logic [APP_ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [7:0]                m_axi_awlen;
  logic [2:0]                m_axi_awsize;
  logic [1:0]                m_axi_awburst;
  logic                      m_axi_awlock;
  logic [3:0]                m_axi_awcache;
  logic [2:0]                m_axi_awprot;
  logic [3:0]                m_axi_awqos;
  logic                      m_axi_awvalid;
  logic                      m_axi_awready;
  // AXI write data
  logic [APP_DATA_WIDTH-1:0] m_axi_wdata;
  logic [APP_MASK_WIDTH-1:0] m_axi_wstrb;
  logic                      m_axi_wlast;
  logic                      m_axi_wvalid;
  logic                      m_axi_wready;
  // AXI write response
  logic [3:0]                m_axi_bid;
  logic [1:0]                m_axi_bresp;
  logic                      m_axi_bvalid;
  logic                      m_axi_bready;
  // AXI read address
  logic [3:0]                m_axi_arid;
  logic [APP_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]                m_axi_arlen;
  logic [2:0]                m_axi_arsize;
  logic [1:0]                m_axi_arburst;
  logic                      m_axi_arlock;
  logic [3:0]                m_axi_arcache;
  logic [2:0]                m_axi_arprot;
  logic [3:0]                m_axi_arqos;
  logic                      m_axi_arvalid;
  logic                      m_axi_arready;
  // AXI read data
  logic [3:0]                m_axi_rid;
  logic [APP_DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]                m_axi_rresp;
  logic                      m_axi_rlast;
  logic                      m_axi_rvalid;
  logic                      m_axi_rready;

  modport master (
    input  init_calib_complete, req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output init_calib_complete, req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );

endinterface
`default_nettype wire

// File: rtl/m_dram_axi_master_lane_sel.sv
`default_nettype none
// ============================================================================
//  Module   : m_lane_sel
//  Purpose  : 32-bit word <-> 128-bit AXI line lane replicate/shift/select.
//  Revision : 1.0  initial release
// ============================================================================
module m_lane_sel (
  input  logic [1:0]   i_wr_lane,
  input  logic [31:0]  i_word_wdata,
  input  logic [3:0]   i_word_wstrb,
  output logic [127:0] o_line_wdata,
  output logic [15:0]  o_line_wstrb,
  input  logic [1:0]   i_rd_lane,
  input  logic [127:0] i_line_rdata,
  output logic [31:0]  o_word_rdata
);

  // The word is copied into every lane; only the strobes pick the real lane.
  assign o_line_wdata = {4{i_word_wdata}};
  assign o_line_wstrb = {12'b0, i_word_wstrb} << {i_wr_lane, 2'b00};
  assign o_word_rdata = i_line_rdata[{i_rd_lane, 5'b00000} +: 32];

endmodule
`default_nettype wire

// File: rtl/m_dram_axi_master.sv
`default_nettype none
// ============================================================================
//  Module   : m_dram_axi_master
//  Purpose  : Single-outstanding AXI4 master turning 32-bit core requests into
//             single-beat 128-bit transactions for the MIG AXI slave port.
//  Revision : 1.0  initial release
// ============================================================================
module m_dram_axi_master
  import dram_axi_pkg::*;
#(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  m_dram_axi_master_if.master  bus
);

  localparam logic [2:0] c_st_idle    = ST_IDLE;
  localparam logic [2:0] c_st_wr      = ST_WR;
  localparam logic [2:0] c_st_wr_resp = ST_WR_RESP;
  localparam logic [2:0] c_st_rd_addr = ST_RD_ADDR;
  localparam logic [2:0] c_st_rd_data = ST_RD_DATA;

  logic [2:0]                r_state;
  logic [APP_ADDR_WIDTH-1:0] r_axi_addr;
  logic [APP_DATA_WIDTH-1:0] r_wdata;
  logic [APP_MASK_WIDTH-1:0] r_wstrb;
  logic [1:0]                r_lane;
  logic                      r_awvalid;
  logic                      r_wvalid;
  logic                      r_arvalid;
  logic                      r_bready;
  logic                      r_rready;
  logic                      r_resp_valid;
  logic                      r_resp_err;
  logic [31:0]               r_resp_rdata;

  logic                      w_req_ready;
  logic                      w_accept;
  logic                      w_aw_done;
  logic                      w_w_done;
  logic [APP_DATA_WIDTH-1:0] w_line_wdata;
  logic [APP_MASK_WIDTH-1:0] w_line_wstrb;
  logic [31:0]               w_word_rdata;
  logic                      w_unused;

  assign w_req_ready = (r_state == c_st_idle) && bus.init_calib_complete;
  assign w_accept    = bus.req_valid && w_req_ready;
  // A channel counts as done once its valid is gone or it handshakes now.
  assign w_aw_done   = !r_awvalid || bus.m_axi_awready;
  assign w_w_done    = !r_wvalid  || bus.m_axi_wready;

  // Byte lanes outside the request word and the single-beat ids/last are not needed.
  assign w_unused = ^{bus.req_addr[1:0], bus.m_axi_bid, bus.m_axi_rid, bus.m_axi_rlast};

  m_lane_sel u_lane_sel (
    .i_wr_lane    (bus.req_addr[3:2]),
    .i_word_wdata (bus.req_wdata),
    .i_word_wstrb (bus.req_wstrb),
    .o_line_wdata (w_line_wdata),
    .o_line_wstrb (w_line_wstrb),
    .i_rd_lane    (r_lane),
    .i_line_rdata (bus.m_axi_rdata),
    .o_word_rdata (w_word_rdata)
  );

  // Transaction FSM: capture the request, drive each AXI phase, report completion.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state      <= c_st_idle;
      r_axi_addr   <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_lane       <= 2'd0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_bready     <= 1'b0;
      r_rready     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_axi_addr <= {bus.req_addr[APP_ADDR_WIDTH-1:4], 4'b0000};
            r_lane     <= bus.req_addr[3:2];
            r_wdata    <= w_line_wdata;
            r_wstrb    <= w_line_wstrb;
            if (bus.req_we) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= c_st_wr;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= c_st_rd_addr;
            end
          end
        end
        c_st_wr: begin
          if (r_awvalid && bus.m_axi_awready) r_awvalid <= 1'b0;
          if (r_wvalid  && bus.m_axi_wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= c_st_wr_resp;
          end
        end
        c_st_wr_resp: begin
          if (bus.m_axi_bvalid) begin
            r_bready     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= resp_is_err(bus.m_axi_bresp);
            r_state      <= c_st_idle;
          end
        end
        c_st_rd_addr: begin
          if (bus.m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= c_st_rd_data;
          end
        end
        c_st_rd_data: begin
          if (bus.m_axi_rvalid) begin
            r_rready     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= resp_is_err(bus.m_axi_rresp);
            r_resp_rdata <= w_word_rdata;
            r_state      <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_rdata    = r_resp_rdata;
  assign bus.resp_err      = r_resp_err;

  assign bus.m_axi_awid    = 4'd0;
  assign bus.m_axi_awaddr  = r_axi_addr;
  assign bus.m_axi_awlen   = 8'd0;
  assign bus.m_axi_awsize  = AXI_SIZE_16B;
  assign bus.m_axi_awburst = AXI_BURST_INCR;
  assign bus.m_axi_awlock  = 1'b0;
  assign bus.m_axi_awcache = AXI_CACHE_DEF;
  assign bus.m_axi_awprot  = 3'd0;
  assign bus.m_axi_awqos   = 4'd0;
  assign bus.m_axi_awvalid = r_awvalid;

  assign bus.m_axi_wdata   = r_wdata;
  assign bus.m_axi_wstrb   = r_wstrb;
  assign bus.m_axi_wlast   = 1'b1;
  assign bus.m_axi_wvalid  = r_wvalid;
  assign bus.m_axi_bready  = r_bready;

  assign bus.m_axi_arid    = 4'd0;
  assign bus.m_axi_araddr  = r_axi_addr;
  assign bus.m_axi_arlen   = 8'd0;
  assign bus.m_axi_arsize  = AXI_SIZE_16B;
  assign bus.m_axi_arburst = AXI_BURST_INCR;
  assign bus.m_axi_arlock  = 1'b0;
  assign bus.m_axi_arcache = AXI_CACHE_DEF;
  assign bus.m_axi_arprot  = 3'd0;
  assign bus.m_axi_arqos   = 4'd0;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_m_dram_axi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m_dram_axi_master
//  Purpose  : Self-checking bench: directed and random word requests against a
//             word-addressed reference memory and a cycle-stepped AXI slave.
//  Revision : 1.0  initial release
// ============================================================================
module tb_m_dram_axi_master;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  m_dram_axi_master_if #(.APP_ADDR_WIDTH(28), .APP_DATA_WIDTH(128), .APP_MASK_WIDTH(16)) bus ();

  m_dram_axi_master #(.APP_ADDR_WIDTH(28), .APP_DATA_WIDTH(128), .APP_MASK_WIDTH(16)) dut (
    .CLK   (clk),
    .RST_X (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: what the core should read back, kept per 32-bit word.
  logic [31:0]  ref_mem [int];
  // Slave storage: what the DDR would hold, kept per 128-bit line.
  logic [127:0] slv_mem [int];

  localparam logic [28:0] AX_CONST = {4'd0, 8'd0, 3'b100, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0};

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  function automatic void ref_wr(input int w, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = ref_rd(w);
    for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
    ref_mem[w] = v;
  endfunction

  function automatic logic [127:0] slv_rd(input logic [27:0] a);
    int idx;
    idx = int'(a[27:4]);
    return slv_mem.exists(idx) ? slv_mem[idx] : 128'h0;
  endfunction

  function automatic void slv_wr(input logic [27:0] a, input logic [127:0] d, input logic [15:0] s);
    logic [127:0] v;
    v = slv_rd(a);
    for (int i = 0; i < 16; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
    slv_mem[int'(a[27:4])] = v;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One core request end to end; abort asserts reset during the B phase.
  task automatic do_txn(input bit we, input logic [27:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input int aw_d, input int w_d, input int ar_d,
                        input int rsp_d, input logic [1:0] code, input bit abort);
    int k;
    bit aw_done, w_done, ar_done, hs;
    logic [1:0]   lane;
    logic [15:0]  exp_strb;
    lane     = addr[3:2];
    exp_strb = 16'({12'b0, ws} << (4 * lane));
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_wstrb = ws;
    #1;
    check("req_ready_idle", bus.req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (we) begin
      ref_wr(int'(addr[27:2]), wd, ws);
      check("awaddr", bus.m_axi_awaddr, {addr[27:4], 4'h0});
      check("wdata", bus.m_axi_wdata, {4{wd}});
      check("wstrb", bus.m_axi_wstrb, exp_strb);
      check("aw_const", {bus.m_axi_awid, bus.m_axi_awlen, bus.m_axi_awsize, bus.m_axi_awburst,
            bus.m_axi_awlock, bus.m_axi_awcache, bus.m_axi_awprot, bus.m_axi_awqos}, AX_CONST);
      check("wlast", bus.m_axi_wlast, 1'b1);
      aw_done = 0; w_done = 0; k = 0;
      while (!(aw_done && w_done) && k < 40) begin
        check("awvalid", bus.m_axi_awvalid, !aw_done);
        check("wvalid", bus.m_axi_wvalid, !w_done);
        check("bready_early", bus.m_axi_bready, 1'b0);
        check("req_ready_busy", bus.req_ready, 1'b0);
        bus.m_axi_awready = (k >= aw_d);
        bus.m_axi_wready  = (k >= w_d);
        if (bus.m_axi_wvalid && bus.m_axi_wready)
          slv_wr(bus.m_axi_awaddr, bus.m_axi_wdata, bus.m_axi_wstrb);
        @(posedge clk);
        if (bus.m_axi_awready) aw_done = 1;
        if (bus.m_axi_wready)  w_done  = 1;
        @(negedge clk);
        k++;
      end
      check("aw_w_in_time", k < 40, 1'b1);
      bus.m_axi_awready = 1'b0;
      bus.m_axi_wready  = 1'b0;
      if (abort) begin
        check("bready_before_rst", bus.m_axi_bready, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_handshakes", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
              bus.m_axi_bready, bus.m_axi_rready, bus.resp_valid, bus.resp_err}, 7'd0);
        check("rst_payload", {bus.m_axi_awaddr, bus.m_axi_wstrb}, 44'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_rst", bus.req_ready, 1'b1);
        return;
      end
      k = 0; hs = 0;
      while (!hs && k < 40) begin
        check("bready", bus.m_axi_bready, 1'b1);
        check("awwvalid_low", {bus.m_axi_awvalid, bus.m_axi_wvalid}, 2'b00);
        check("resp_valid_wait", bus.resp_valid, 1'b0);
        bus.m_axi_bvalid = (k >= rsp_d);
        bus.m_axi_bresp  = code;
        @(posedge clk);
        hs = bus.m_axi_bvalid;
        @(negedge clk);
        k++;
      end
      check("b_in_time", hs, 1'b1);
      bus.m_axi_bvalid = 1'b0;
      check("bready_drop", bus.m_axi_bready, 1'b0);
    end else begin
      check("araddr", bus.m_axi_araddr, {addr[27:4], 4'h0});
      check("ar_const", {bus.m_axi_arid, bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst,
            bus.m_axi_arlock, bus.m_axi_arcache, bus.m_axi_arprot, bus.m_axi_arqos}, AX_CONST);
      ar_done = 0; k = 0;
      while (!ar_done && k < 40) begin
        check("arvalid", bus.m_axi_arvalid, 1'b1);
        check("rready_early", bus.m_axi_rready, 1'b0);
        check("req_ready_busy", bus.req_ready, 1'b0);
        bus.m_axi_arready = (k >= ar_d);
        @(posedge clk);
        ar_done = bus.m_axi_arready;
        @(negedge clk);
        k++;
      end
      check("ar_in_time", ar_done, 1'b1);
      bus.m_axi_arready = 1'b0;
      k = 0; hs = 0;
      while (!hs && k < 40) begin
        check("rready", bus.m_axi_rready, 1'b1);
        check("arvalid_low", bus.m_axi_arvalid, 1'b0);
        check("resp_valid_wait", bus.resp_valid, 1'b0);
        bus.m_axi_rvalid = (k >= rsp_d);
        bus.m_axi_rdata  = slv_rd(addr);
        bus.m_axi_rresp  = code;
        bus.m_axi_rlast  = 1'b1;
        @(posedge clk);
        hs = bus.m_axi_rvalid;
        @(negedge clk);
        k++;
      end
      check("r_in_time", hs, 1'b1);
      bus.m_axi_rvalid = 1'b0;
      check("rready_drop", bus.m_axi_rready, 1'b0);
      check("resp_rdata", bus.resp_rdata, ref_rd(int'(addr[27:2])));
    end
    check("resp_valid", bus.resp_valid, 1'b1);
    check("resp_err", bus.resp_err, code != 2'b00);
    check("req_ready_on_resp", bus.req_ready, bus.init_calib_complete);
    @(posedge clk);
    @(negedge clk);
    check("resp_valid_pulse", bus.resp_valid, 1'b0);
  endtask

  initial begin
    logic [27:0] a;
    rst_n = 1'b0;
    bus.init_calib_complete = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_wstrb = '0;
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
    bus.m_axi_bid = '0; bus.m_axi_bresp = '0; bus.m_axi_bvalid = 1'b0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rid = '0; bus.m_axi_rdata = '0; bus.m_axi_rresp = '0;
    bus.m_axi_rlast = 1'b0; bus.m_axi_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_resp", {bus.resp_valid, bus.resp_err, bus.resp_rdata}, 34'd0);
    check("rst_valids", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
          bus.m_axi_bready, bus.m_axi_rready}, 5'd0);
    check("rst_regs", {bus.m_axi_awaddr, bus.m_axi_wdata, bus.m_axi_wstrb}, 172'd0);
    rst_n = 1'b1;
    bus.init_calib_complete = 1'b1;
    @(negedge clk);

    // Directed: minimum-latency write, then reads of the two lanes in that line.
    do_txn(1'b1, 28'h000_0108, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, 1'b0);
    ref_wr(int'(28'h10C >> 2), 32'h12345678, 4'hF);
    slv_wr(28'h000_0100, {32'h12345678, 96'h0}, 16'hF000);
    do_txn(1'b0, 28'h000_010C, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 1'b0);
    do_txn(1'b0, 28'h000_0108, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 1'b0);
    // Independent AW/W ready delays, then SLVERR read followed by a normal one.
    do_txn(1'b1, 28'h000_0024, 32'hCAFE0001, 4'h5, 3, 1, 0, 2, 2'b00, 1'b0);
    do_txn(1'b0, 28'h000_0024, 32'h0, 4'h0, 0, 0, 1, 1, 2'b10, 1'b0);
    do_txn(1'b0, 28'h000_0024, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 1'b0);

    // Calibration not done: request held, nothing issued.
    bus.init_calib_complete = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 28'h000_0030;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("calib_req_ready", bus.req_ready, 1'b0);
      check("calib_no_valid", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid}, 3'd0);
      @(negedge clk);
    end
    bus.init_calib_complete = 1'b1;
    do_txn(1'b0, 28'h000_0030, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 1'b0);

    // Reset while waiting for B, then a read of the written word.
    do_txn(1'b1, 28'h000_0044, 32'hA5A55A5A, 4'hF, 0, 0, 0, 0, 2'b00, 1'b1);
    do_txn(1'b0, 28'h000_0044, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 1'b0);

    // Random mix over a small address window so reads hit earlier writes.
    for (int n = 0; n < 60; n++) begin
      a = {20'h0, 4'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
